// File: rtl/fitness_eval_scheduler_if.sv
// rtl/fitness_eval_scheduler_if.sv - population RAM, evaluator and fitness RAM bus of the scheduler
// master: scheduler side; slave: memories and evaluator side.
interface fitness_eval_scheduler_if #(
  parameter int ADDR_WIDTH               = 3,
  parameter int INDIVIDUAL_LENGTH        = 44,
  parameter int SELF_ENERGY_VEC_LENGTH   = 12,
  parameter int INTERATION_MATRIX_LENGTH = 36,
  parameter int SELF_FIT_LENGTH          = 10
);
  logic                                pop_rd_en_o;
  logic [ADDR_WIDTH-1:0]               pop_rd_addr_o;
  logic [INDIVIDUAL_LENGTH-1:0]        pop_rd_data_i;
  logic                                eval_in_valid_o;
  logic [SELF_ENERGY_VEC_LENGTH-1:0]   eval_self_energy_o;
  logic [INTERATION_MATRIX_LENGTH-1:0] eval_interact_o;
  logic [INDIVIDUAL_LENGTH-1:0]        eval_ind_o;
  logic                                eval_out_valid_i;
  logic [SELF_FIT_LENGTH-1:0]          eval_fit_i;
  logic                                fit_wr_en_o;
  logic [ADDR_WIDTH-1:0]               fit_wr_addr_o;
  logic [SELF_FIT_LENGTH-1:0]          fit_wr_data_o;

  modport master (
    output pop_rd_en_o, pop_rd_addr_o, eval_in_valid_o, eval_self_energy_o,
           eval_interact_o, eval_ind_o, fit_wr_en_o, fit_wr_addr_o, fit_wr_data_o,
    input  pop_rd_data_i, eval_out_valid_i, eval_fit_i
  );

  modport slave (
    input  pop_rd_en_o, pop_rd_addr_o, eval_in_valid_o, eval_self_energy_o,
           eval_interact_o, eval_ind_o, fit_wr_en_o, fit_wr_addr_o, fit_wr_data_o,
    output pop_rd_data_i, eval_out_valid_i, eval_fit_i
  );
endinterface

// File: rtl/fitness_eval_scheduler.sv
// rtl/fitness_eval_scheduler.sv - sweeps the population through the fitness evaluator
// Reads each individual, issues it, waits (with timeout) for the fitness, writes it back, tracks the minimum.
module fitness_eval_scheduler #(
  parameter int POP_SIZE                 = 8,
  parameter int ADDR_WIDTH               = 3,
  parameter int INDIVIDUAL_LENGTH        = 44,
  parameter int SELF_ENERGY_VEC_LENGTH   = 12,
  parameter int INTERATION_MATRIX_LENGTH = 36,
  parameter int SELF_FIT_LENGTH          = 10,
  parameter int TIMEOUT_CYCLES           = 255
) (
  input  logic                                clk_i,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic                                abort_i,
  input  logic [SELF_ENERGY_VEC_LENGTH-1:0]   self_energy_vec_i,
  input  logic [INTERATION_MATRIX_LENGTH-1:0] interact_matrix_i,
  fitness_eval_scheduler_if.master            bus,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [SELF_FIT_LENGTH-1:0]          best_fit_o,
  output logic [ADDR_WIDTH-1:0]               best_idx_o,
  output logic                                timeout_err_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(POP_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t                              state_q, state_d;
  logic [ADDR_WIDTH-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [INDIVIDUAL_LENGTH-1:0]        ind_q, ind_d;
  logic [SELF_FIT_LENGTH-1:0]          result_q, result_d;
  logic [SELF_ENERGY_VEC_LENGTH-1:0]   se_q, se_d;
  logic [INTERATION_MATRIX_LENGTH-1:0] im_q, im_d;
  logic [SELF_FIT_LENGTH-1:0]          best_fit_q, best_fit_d;
  logic [ADDR_WIDTH-1:0]               best_idx_q, best_idx_d;
  logic                                err_q, err_d;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      ind_q      <= '0;
      result_q   <= '0;
      se_q       <= '0;
      im_q       <= '0;
      best_fit_q <= '0;
      best_idx_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ind_q      <= ind_d;
      result_q   <= result_d;
      se_q       <= se_d;
      im_q       <= im_d;
      best_fit_q <= best_fit_d;
      best_idx_q <= best_idx_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ind_d      = ind_q;
    result_d   = result_q;
    se_d       = se_q;
    im_d       = im_q;
    best_fit_d = best_fit_q;
    best_idx_d = best_idx_q;
    err_d      = err_q;
    // Abort beats every other transition and freezes the best/error results.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d    = S_READ;
            idx_d      = '0;
            se_d       = self_energy_vec_i;
            im_d       = interact_matrix_i;
            best_fit_d = '1;
            best_idx_d = '0;
            err_d      = 1'b0;
          end
        end
        S_READ:  state_d = S_LOAD;
        S_LOAD: begin
          ind_d   = bus.pop_rd_data_i;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the final timeout cycle still counts as valid.
          if (bus.eval_out_valid_i) begin
            result_d = bus.eval_fit_i;
            state_d  = S_WRITE;
          end else if (cnt_q == CNT_LAST) begin
            result_d = '1;
            err_d    = 1'b1;
            state_d  = S_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (result_q < best_fit_q) begin
            best_fit_d = result_q;
            best_idx_d = idx_q;
          end
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.pop_rd_en_o        = (state_q == S_READ);
  assign bus.pop_rd_addr_o      = idx_q;
  assign bus.eval_in_valid_o    = (state_q == S_ISSUE);
  assign bus.eval_ind_o         = ind_q;
  assign bus.eval_self_energy_o = se_q;
  assign bus.eval_interact_o    = im_q;
  assign bus.fit_wr_en_o        = (state_q == S_WRITE);
  assign bus.fit_wr_addr_o      = idx_q;
  assign bus.fit_wr_data_o      = result_q;
  assign busy_o                 = (state_q != S_IDLE);
  assign done_o                 = (state_q == S_DONE);
  assign best_fit_o             = best_fit_q;
  assign best_idx_o             = best_idx_q;
  assign timeout_err_o          = err_q;
endmodule

// File: tb/tb_fitness_eval_scheduler.sv
// tb/tb_fitness_eval_scheduler.sv - self-checking bench for fitness_eval_scheduler
// Models the population RAM and a latency-programmable evaluator; predicts each sweep from the rules.
module tb_fitness_eval_scheduler;
  localparam int P  = 8;
  localparam int AW = 3;
  localparam int IL = 44;
  localparam int SE = 12;
  localparam int IM = 36;
  localparam int FW = 10;
  localparam int T  = 4;

  logic          clk_i = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [SE-1:0] se_in = '0;
  logic [IM-1:0] im_in = '0;
  logic          busy_o, done_o, timeout_err_o;
  logic [FW-1:0] best_fit_o;
  logic [AW-1:0] best_idx_o;

  fitness_eval_scheduler_if #(.ADDR_WIDTH(AW), .INDIVIDUAL_LENGTH(IL), .SELF_ENERGY_VEC_LENGTH(SE),
    .INTERATION_MATRIX_LENGTH(IM), .SELF_FIT_LENGTH(FW)) bus ();

  fitness_eval_scheduler #(.POP_SIZE(P), .ADDR_WIDTH(AW), .INDIVIDUAL_LENGTH(IL),
    .SELF_ENERGY_VEC_LENGTH(SE), .INTERATION_MATRIX_LENGTH(IM), .SELF_FIT_LENGTH(FW),
    .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .self_energy_vec_i(se_in), .interact_matrix_i(im_in), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .best_fit_o(best_fit_o), .best_idx_o(best_idx_o),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [IL-1:0] pop_mem [P];
  logic [FW-1:0] fitv [P];
  int            lat [P];
  bit            spurious = 1'b0;

  // Monitor: log writes, done pulses and the cycle of the first READ of a sweep.
  int            cyc = 0, wr_n = 0, done_n = 0, rd0_cyc = 0, done_cyc = 0;
  logic [AW-1:0] wa_log [$];
  logic [FW-1:0] wd_log [$];
  always @(negedge clk_i) begin
    cyc++;
    if (!rst) begin
      if (bus.pop_rd_en_o && bus.pop_rd_addr_o == '0) rd0_cyc = cyc;
      if (bus.fit_wr_en_o) begin
        wa_log.push_back(bus.fit_wr_addr_o);
        wd_log.push_back(bus.fit_wr_data_o);
        wr_n++;
      end
      if (done_o) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  // Population RAM: data appears one cycle after the read strobe.
  initial begin
    logic [AW-1:0] a;
    bus.pop_rd_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (bus.pop_rd_en_o) begin
        a = bus.pop_rd_addr_o;
        @(posedge clk_i);
        #1 bus.pop_rd_data_i = pop_mem[a];
      end
    end
  end

  // Evaluator: answers lat[k] cycles after the issue cycle; lat 0 means silent.
  initial begin
    int k;
    bus.eval_out_valid_i = 1'b0;
    bus.eval_fit_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst && bus.eval_in_valid_o) begin
        k = int'(bus.eval_ind_o[AW-1:0]);
        check_eq("eval_ind", 64'(bus.eval_ind_o), 64'(pop_mem[k]));
        if (lat[k] > 0) begin
          repeat (lat[k]) @(negedge clk_i);
          bus.eval_out_valid_i = 1'b1;
          bus.eval_fit_i = fitv[k];
          @(negedge clk_i);
          bus.eval_out_valid_i = 1'b0;
        end
      end else if (!rst && spurious && bus.pop_rd_en_o) begin
        bus.eval_out_valid_i = 1'b1;
        bus.eval_fit_i = '0;
        @(negedge clk_i);
        bus.eval_out_valid_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic fill_pop();
    logic [63:0] t;
    for (int i = 0; i < P; i++) begin
      t = {$urandom, $urandom};
      pop_mem[i] = {t[IL-AW-1:0], AW'(i)};
    end
  endtask

  task automatic wait_done(input int dbase, input string tag);
    int budget = 0;
    while (done_n == dbase && budget < 2000) begin
      tick();
      budget++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_n - dbase), 64'd1);
  endtask

  task automatic run_sweep(input string tag, input bit hold_start);
    int            base = wr_n;
    int            dbase = done_n;
    int            exp_len = 0;
    logic [FW-1:0] ef [P];
    logic [FW-1:0] bf = '1;
    logic [AW-1:0] bi = '0;
    logic          eerr = 1'b0;
    logic [SE-1:0] se_cap;
    logic [IM-1:0] im_cap;
    for (int i = 0; i < P; i++) begin
      if (lat[i] >= 1 && lat[i] <= T) begin
        ef[i] = fitv[i];
        exp_len += 4 + lat[i];
      end else begin
        ef[i] = '1;
        eerr = 1'b1;
        exp_len += 4 + T;
      end
      if (ef[i] < bf) begin
        bf = ef[i];
        bi = AW'(i);
      end
    end
    fill_pop();
    se_cap = se_in;
    im_cap = im_in;
    start_i = 1'b1;
    tick();
    start_i = hold_start;
    check_eq({tag, "_busy_rise"}, 64'(busy_o), 64'd1);
    se_in = SE'($urandom);
    im_in = {4'($urandom), $urandom};
    wait_done(dbase, tag);
    check_eq({tag, "_wr_count"}, 64'(wr_n - base), 64'(P));
    for (int i = 0; i < P; i++) begin
      if (base + i < wr_n) begin
        check_eq($sformatf("%s_wr_addr%0d", tag, i), 64'(wa_log[base + i]), 64'(i));
        check_eq($sformatf("%s_wr_data%0d", tag, i), 64'(wd_log[base + i]), 64'(ef[i]));
      end
    end
    check_eq({tag, "_best_fit"}, 64'(best_fit_o), 64'(bf));
    check_eq({tag, "_best_idx"}, 64'(best_idx_o), 64'(bi));
    check_eq({tag, "_timeout_err"}, 64'(timeout_err_o), 64'(eerr));
    check_eq({tag, "_sweep_len"}, 64'(done_cyc - rd0_cyc), 64'(exp_len));
    check_eq({tag, "_cfg_se"}, 64'(bus.eval_self_energy_o), 64'(se_cap));
    check_eq({tag, "_cfg_im"}, 64'(bus.eval_interact_o), 64'(im_cap));
    tick();
    check_eq({tag, "_done_width"}, 64'(done_o), 64'd0);
    check_eq({tag, "_busy_fall"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int base, dbase, budget;
    logic [FW-1:0] directed [P];
    directed = '{10'd50, 10'd30, 10'd70, 10'd30, 10'd90, 10'd10, 10'd10, 10'd60};
    for (int i = 0; i < P; i++) begin
      lat[i] = 2;
      fitv[i] = directed[i];
    end
    fill_pop();
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_outs", 64'({bus.pop_rd_en_o, bus.pop_rd_addr_o, bus.eval_in_valid_o,
             bus.fit_wr_en_o, bus.fit_wr_addr_o, bus.fit_wr_data_o}), 64'd0);
    check_eq("rst_best", 64'({best_fit_o, best_idx_o, timeout_err_o}), 64'd0);
    check_eq("rst_regs", 64'(bus.eval_ind_o), 64'd0);
    check_eq("rst_cfg", 64'({bus.eval_self_energy_o, bus.eval_interact_o[IM-1:IM-8]}), 64'd0);
    check_eq("rst_im", 64'(bus.eval_interact_o), 64'd0);
    se_in = 12'hA5C;
    im_in = 36'h9_1234_5678;
    rst = 1'b0;
    tick();

    run_sweep("basic", 1'b0);

    lat[3] = 0;
    run_sweep("timeout", 1'b0);
    lat[3] = 2;
    run_sweep("err_clear", 1'b0);

    lat[4] = T;
    run_sweep("race", 1'b0);
    lat[4] = 2;

    lat[2] = 0;
    base = wr_n;
    dbase = done_n;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    budget = 0;
    while (!(bus.eval_in_valid_o && bus.eval_ind_o[AW-1:0] == 3'd2) && budget < 200) begin
      tick();
      budget++;
    end
    check_eq("abort_reach_issue2", 64'(bus.eval_in_valid_o), 64'd1);
    tick();
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_eq("abort_idle", 64'(busy_o), 64'd0);
    repeat (20) tick();
    check_eq("abort_writes", 64'(wr_n - base), 64'd2);
    check_eq("abort_no_done", 64'(done_n - dbase), 64'd0);
    check_eq("abort_best", 64'(best_fit_o), 64'(fitv[1]));
    lat[2] = 2;
    run_sweep("restart", 1'b0);

    spurious = 1'b1;
    for (int i = 0; i < P; i++) begin
      lat[i] = $urandom_range(1, T);
      fitv[i] = FW'($urandom);
    end
    run_sweep("spurious", 1'b0);
    spurious = 1'b0;

    base = wr_n;
    dbase = done_n;
    run_sweep("hold", 1'b1);
    tick();
    check_eq("hold_restart", 64'(busy_o), 64'd1);
    start_i = 1'b0;
    wait_done(dbase + 1, "hold2");
    check_eq("hold2_writes", 64'(wr_n - base), 64'(2 * P));
    repeat (3) tick();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < P; i++) begin
        lat[i] = $urandom_range(0, 6);
        fitv[i] = FW'($urandom);
      end
      run_sweep($sformatf("rand%0d", r), 1'b0);
    end

    for (int i = 0; i < P; i++) lat[i] = 2;
    base = wr_n;
    dbase = done_n;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    budget = 0;
    while (!(bus.fit_wr_en_o && bus.fit_wr_addr_o == 3'd3) && budget < 200) begin
      tick();
      budget++;
    end
    check_eq("rstw_reach_write3", 64'(bus.fit_wr_en_o), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rstw_outs", 64'({bus.fit_wr_en_o, bus.fit_wr_addr_o, bus.fit_wr_data_o, busy_o, done_o}), 64'd0);
    check_eq("rstw_best", 64'({best_fit_o, best_idx_o, timeout_err_o}), 64'd0);
    check_eq("rstw_regs", 64'(bus.eval_ind_o), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    check_eq("rstw_writes", 64'(wr_n - base), 64'd4);
    check_eq("rstw_no_done", 64'(done_n - dbase), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
